pid_cfg_writer: RTL and testbench

PID_CFG_WRITER -- requirements
Module: pid_cfg_writer

---
 rtl/pid_cfg_writer.sv | 121 ++++++++++++
 tb/tb_pid_cfg_writer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pid_cfg_writer.sv
// Buffers host (addr, data) register writes in a small FIFO and replays them to a
// PID core as active-low write strobes, arbitrating against the PID iteration enable.
module pid_cfg_writer #(
  parameter int D_WIDTH    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [D_WIDTH-1:0] cfg_addr,
  input  logic [D_WIDTH-1:0] cfg_data,
  input  logic               run_req,
  input  logic               stop_req,
  output logic               write_enable,
  output logic               iterate_enable,
  output logic [D_WIDTH-1:0] reg_addr,
  output logic [D_WIDTH-1:0] reg_data,
  output logic               busy,
  output logic               cfg_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WRITE, RUN} state_t;

  state_t             state, state_next;
  logic               pending, pending_next;
  logic               iterate_next;
  logic [D_WIDTH-1:0] addr_mem [FIFO_DEPTH];
  logic [D_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               empty, push, pop, last_pop, legal, run_eff;
  logic [D_WIDTH-1:0] head_addr, head_data;

  assign empty     = (count == '0);
  assign cfg_ready = (count < CNT_W'(FIFO_DEPTH));
  assign push      = cfg_valid && cfg_ready;
  assign pop       = (state == WRITE) && !empty;
  assign last_pop  = pop && (count == CNT_W'(1)) && !push;
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign legal     = (head_addr < D_WIDTH'(NUM_REGS));
  assign run_eff   = run_req && !stop_req;
  assign busy      = (state == WRITE) || !empty;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_next   = state;
    pending_next = pending && !stop_req;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          state_next = WRITE;
          if (run_eff) pending_next = 1'b1;
        end else if (run_eff || pending_next) begin
          state_next   = RUN;
          pending_next = 1'b0;
        end
      end
      WRITE: begin
        if (run_eff) pending_next = 1'b1;
        if (last_pop || empty) begin
          state_next   = pending_next ? RUN : IDLE;
          pending_next = 1'b0;
        end
      end
      RUN: begin
        if (stop_req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Leaving WRITE, the final strobe is still on the bus; hold off iteration one cycle.
    iterate_next = (state_next == RUN) && (state != WRITE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state          <= IDLE;
      pending        <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      write_enable   <= 1'b1;
      iterate_enable <= 1'b0;
      reg_addr       <= '0;
      reg_data       <= '0;
      cfg_err        <= 1'b0;
    end else begin
      state          <= state_next;
      pending        <= pending_next;
      iterate_enable <= iterate_next;
      write_enable   <= !(pop && legal);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop && legal) begin
        reg_addr <= head_addr;
        reg_data <= head_data;
      end
      if (pop && !legal) cfg_err <= 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= cfg_addr;
      data_mem[wr_ptr] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_pid_cfg_writer.sv
// Directed bench for pid_cfg_writer: reset, write sequencing, run/stop arbitration,
// illegal addresses, mid-burst reset and full-FIFO draining.
module tb_pid_cfg_writer;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        run_req = 1'b0;
  logic        stop_req = 1'b0;
  logic        write_enable, iterate_enable, busy, cfg_err;
  logic [15:0] reg_addr, reg_data;

  int vectors = 0;
  int miscompares = 0;

  pid_cfg_writer #(.D_WIDTH(16), .FIFO_DEPTH(4), .NUM_REGS(4)) dut (
    .clk(clk), .rstb(rstb), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .run_req(run_req), .stop_req(stop_req),
    .write_enable(write_enable), .iterate_enable(iterate_enable),
    .reg_addr(reg_addr), .reg_data(reg_data), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Snapshot layout: {write_enable, iterate_enable, busy, cfg_err, cfg_ready, reg_addr, reg_data}
  function automatic logic [36:0] obs();
    return {write_enable, iterate_enable, busy, cfg_err, cfg_ready, reg_addr, reg_data};
  endfunction

  function automatic logic [36:0] pk(input logic we, ie, bz, er, rdy,
                                     input logic [15:0] a, d);
    return {we, ie, bz, er, rdy, a, d};
  endfunction

  // Drive one cycle of stimulus, let the edge happen, return 1 ns after it.
  task automatic apply(input logic v, input logic [15:0] a, d, input logic run, stop);
    cfg_valid = v; cfg_addr = a; cfg_data = d; run_req = run; stop_req = stop;
    @(posedge clk); #1;
    cfg_valid = 1'b0; run_req = 1'b0; stop_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [36:0] exp;
    #12;
    exp = pk(1, 0, 0, 0, 1, 16'h0, 16'h0);
    vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL reset_hold: got %h expected %h", obs(), exp); end
    rstb = 1'b1;
    apply(0, 0, 0, 0, 0);
    vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL reset_release: got %h expected %h", obs(), exp); end
  endtask

  task automatic test_write_then_run();
    logic [36:0] exp [5];
    exp[0] = pk(1, 0, 1, 0, 1, 16'h0, 16'h0);
    exp[1] = pk(1, 0, 1, 0, 1, 16'h0, 16'h0);
    exp[2] = pk(0, 0, 1, 0, 1, 16'h0, 16'h0200);
    exp[3] = pk(0, 0, 0, 0, 1, 16'h1, 16'h1000);
    exp[4] = pk(1, 1, 0, 0, 1, 16'h1, 16'h1000);
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: apply(1, 16'h0, 16'h0200, 0, 0);
        1: apply(1, 16'h1, 16'h1000, 0, 0);
        2: apply(0, 0, 0, 1, 0);
        default: apply(0, 0, 0, 0, 0);
      endcase
      vectors++;
      if (obs() !== exp[i]) begin
        miscompares++; $display("FAIL write_then_run step %0d: got %h expected %h", i, obs(), exp[i]);
      end
    end
  endtask

  task automatic test_hold_in_run();
    logic [36:0] exp;
    for (int i = 0; i < 5; i++) begin
      apply(1, 16'(i % 4), 16'hA000 + 16'(i), 0, 0);
      exp = pk(1, 1, 1, 0, (i < 3), 16'h1, 16'h1000);
      vectors++;
      if (obs() !== exp) begin miscompares++; $display("FAIL hold_push %0d: got %h expected %h", i, obs(), exp); end
    end
    apply(0, 0, 0, 0, 1);
    exp = pk(1, 0, 1, 0, 0, 16'h1, 16'h1000);
    vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL hold_stop: got %h expected %h", obs(), exp); end
    apply(0, 0, 0, 0, 0);
    vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL hold_to_write: got %h expected %h", obs(), exp); end
    for (int j = 0; j < 4; j++) begin
      apply(0, 0, 0, 0, 0);
      exp = pk(0, 0, (j < 3), 0, 1, 16'(j), 16'hA000 + 16'(j));
      vectors++;
      if (obs() !== exp) begin miscompares++; $display("FAIL hold_drain %0d: got %h expected %h", j, obs(), exp); end
    end
    apply(0, 0, 0, 0, 0);
    exp = pk(1, 0, 0, 0, 1, 16'h3, 16'hA003);
    vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL hold_idle: got %h expected %h", obs(), exp); end
  endtask

  task automatic test_run_stop_arbitration();
    logic [36:0] exp [4];
    exp[0] = pk(1, 0, 0, 0, 1, 16'h3, 16'hA003);
    exp[1] = pk(1, 0, 0, 0, 1, 16'h3, 16'hA003);
    exp[2] = pk(1, 1, 0, 0, 1, 16'h3, 16'hA003);
    exp[3] = pk(1, 0, 0, 0, 1, 16'h3, 16'hA003);
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: apply(0, 0, 0, 1, 1);
        1: apply(0, 0, 0, 0, 0);
        2: apply(0, 0, 0, 1, 0);
        default: apply(0, 0, 0, 0, 1);
      endcase
      vectors++;
      if (obs() !== exp[i]) begin
        miscompares++; $display("FAIL run_stop step %0d: got %h expected %h", i, obs(), exp[i]);
      end
    end
  endtask

  task automatic test_illegal_addr();
    logic [36:0] exp [5];
    exp[0] = pk(1, 0, 1, 0, 1, 16'h3, 16'hA003);
    exp[1] = pk(1, 0, 1, 0, 1, 16'h3, 16'hA003);
    exp[2] = pk(1, 0, 1, 1, 1, 16'h3, 16'hA003);
    exp[3] = pk(0, 0, 0, 1, 1, 16'h2, 16'h0001);
    exp[4] = pk(1, 0, 0, 1, 1, 16'h2, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: apply(1, 16'h5, 16'hABCD, 0, 0);
        1: apply(1, 16'h2, 16'h0001, 0, 0);
        default: apply(0, 0, 0, 0, 0);
      endcase
      vectors++;
      if (obs() !== exp[i]) begin
        miscompares++; $display("FAIL illegal_addr step %0d: got %h expected %h", i, obs(), exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [36:0] exp [4];
    logic [36:0] rst_exp;
    exp[0] = pk(1, 0, 1, 1, 1, 16'h2, 16'h0001);
    exp[1] = pk(1, 0, 1, 1, 1, 16'h2, 16'h0001);
    exp[2] = pk(0, 0, 1, 1, 1, 16'h0, 16'h0C00);
    exp[3] = pk(0, 0, 1, 1, 1, 16'h1, 16'h0C01);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) apply(1, 16'(i), 16'h0C00 + 16'(i), 0, 0);
      else       apply(0, 0, 0, 0, 0);
      vectors++;
      if (obs() !== exp[i]) begin
        miscompares++; $display("FAIL mid_burst step %0d: got %h expected %h", i, obs(), exp[i]);
      end
    end
    rstb = 1'b0;
    #1;
    rst_exp = pk(1, 0, 0, 0, 1, 16'h0, 16'h0);
    vectors++;
    if (obs() !== rst_exp) begin miscompares++; $display("FAIL mid_burst_reset: got %h expected %h", obs(), rst_exp); end
    #2 rstb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0);
      vectors++;
      if (obs() !== rst_exp) begin
        miscompares++; $display("FAIL mid_burst_after %0d: got %h expected %h", i, obs(), rst_exp);
      end
    end
  endtask

  task automatic test_back_to_back_full();
    int c = 0;
    int idx = 0;
    int wr_idx = 0;
    logic acc;
    while (c < 60 && !(c > 10 && idx == 7 && !busy)) begin
      cfg_valid = (c >= 1) && (idx < 7);
      cfg_addr  = 16'(idx % 4);
      cfg_data  = 16'hD000 + 16'(idx);
      run_req   = (c == 0);
      stop_req  = (c == 6);
      acc = cfg_valid && cfg_ready;
      @(posedge clk); #1;
      cfg_valid = 1'b0; run_req = 1'b0; stop_req = 1'b0;
      if (acc) idx++;
      vectors++;
      if (!write_enable && iterate_enable) begin
        miscompares++; $display("FAIL b2b_strobe_during_run cycle %0d: got we=0 ie=1 expected not both", c);
      end
      if (!write_enable) begin
        vectors++;
        if (wr_idx >= 7) begin
          miscompares++; $display("FAIL b2b_extra_strobe: got strobe %0d expected at most 7", wr_idx + 1);
        end else if ({reg_addr, reg_data} !== {16'(wr_idx % 4), 16'hD000 + 16'(wr_idx)}) begin
          miscompares++;
          $display("FAIL b2b_order %0d: got %h/%h expected %h/%h", wr_idx, reg_addr, reg_data,
                   16'(wr_idx % 4), 16'hD000 + 16'(wr_idx));
        end
        wr_idx++;
      end
      c++;
    end
    vectors++;
    if (wr_idx !== 7 || idx !== 7 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_total: got accepted=%0d written=%0d busy=%b expected 7 7 0", idx, wr_idx, busy);
    end
  endtask

  initial begin
    test_reset();
    test_write_then_run();
    test_hold_in_run();
    test_run_stop_arbitration();
    test_illegal_addr();
    test_reset_mid_burst();
    test_back_to_back_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1);
  end

endmodule
